// File: rtl/adc_frame_packer_if.sv
// TLP output bus toward the downstream FIFO, together with its back-pressure flag.
interface adc_frame_packer_if;
    logic [63:0] TLPData;
    logic        DataWriteEnable;
    logic [39:0] TLPHeader;
    logic        HeaderWriteEnable;
    logic        FifoAlmostFull;

    modport master (output TLPData, DataWriteEnable, TLPHeader, HeaderWriteEnable,
                    input  FifoAlmostFull);
    modport slave  (input  TLPData, DataWriteEnable, TLPHeader, HeaderWriteEnable,
                    output FifoAlmostFull);
endinterface

// File: rtl/adc_frame_packer.sv
// Packs ADC samples MSB-first into 64-bit words, groups them into TLPs with headers,
// and drives the optical sync pulse and the polarisation switcher.
module adc_frame_packer #(
    parameter int NUM_CH        = 2,
    parameter int SAMPLE_W      = 12,
    parameter int WORDS_PER_TLP = 16
) (
    input  logic                       InputClock,
    input  logic                       rst,
    input  logic [NUM_CH*SAMPLE_W-1:0] ADC_in,
    input  logic [31:0]                CONFIG_REG_1,
    input  logic [31:0]                CONFIG_REG_2,
    input  logic [15:0]                BufferLengthTLPs,
    adc_frame_packer_if.master         tlpBus,
    output logic                       SyncPulse,
    output logic                       Switcher,
    output logic [15:0]                DropCount
);
    localparam int SPW   = (SAMPLE_W == 8) ? 8 : ((SAMPLE_W == 12) ? 5 : 4);
    localparam int PAD_W = 64 - SPW * SAMPLE_W;
    localparam int TW    = $clog2(WORDS_PER_TLP);
    localparam logic [2:0]    LAST_SAMP = 3'(SPW - 1);
    localparam logic [1:0]    LAST_CH   = 2'(NUM_CH - 1);
    localparam logic [2:0]    NUM_CH_L  = 3'(NUM_CH);
    localparam logic [TW-1:0] LAST_TLPW = TW'(WORDS_PER_TLP - 1);

    typedef enum logic [1:0] {START, FILL, DROP, GAP} state_t;
    state_t state, nextState;

    logic [31:0] cfg1;
    logic [26:0] cfg2;
    logic [15:0] bufLen;
    logic        unusedCfgBits;

    logic [12:0] frameLength;
    logic [6:0]  pulseWidth;
    logic [1:0]  selCh;
    logic        autoCh;
    logic [8:0]  pulseOffset;
    logic [23:0] frameCountToSwitch;
    logic        autoPol, manualPol, testMode;

    logic [2:0]          sampCnt;
    logic [1:0]          chCnt, curCh;
    logic [12:0]         wordCnt;
    logic [23:0]         frameCnt;
    logic [TW-1:0]       tlpWordCnt;
    logic [15:0]         tlpCnt, bufCnt;
    logic [7:0]          testCnt;
    logic                ovfFlag, switchState;
    logic                capturing, wordDone, frameDone, emit, hdr, inPulse;
    logic [9:0]          pulseEnd;
    logic [SAMPLE_W-1:0] rawSample, sample;
    logic [63-SAMPLE_W:0] acc;
    logic [63:0]         accNext, wordOut;

    assign unusedCfgBits      = ^CONFIG_REG_2[31:27];
    assign frameLength        = cfg1[12:0];
    assign pulseWidth         = cfg1[19:13];
    assign selCh              = cfg1[21:20];
    assign autoCh             = cfg1[22];
    assign pulseOffset        = cfg1[31:23];
    assign frameCountToSwitch = cfg2[23:0];
    assign autoPol            = cfg2[24];
    assign manualPol          = cfg2[25];
    assign testMode           = cfg2[26];

    assign Switcher = autoPol ? switchState : manualPol;
    assign pulseEnd = {1'b0, pulseOffset} + {3'b0, pulseWidth};
    assign inPulse  = ({4'b0, pulseOffset} <= wordCnt) && (wordCnt <= {3'b0, pulseEnd});

    always_ff @(posedge InputClock) begin
        if (rst) state <= START;
        else     state <= nextState;
    end

    always_comb begin
        nextState = state;
        capturing = 1'b0;
        wordDone  = 1'b0;
        frameDone = 1'b0;
        emit      = 1'b0;
        hdr       = 1'b0;
        case (state)
            START: nextState = tlpBus.FifoAlmostFull ? DROP : FILL;
            FILL, DROP: begin
                capturing = 1'b1;
                wordDone  = (sampCnt == LAST_SAMP);
                frameDone = wordDone && (wordCnt == frameLength);
                emit      = wordDone && (state == FILL);
                hdr       = emit && (tlpWordCnt == LAST_TLPW);
                if (frameDone) nextState = GAP;
            end
            GAP:     nextState = START;
            default: nextState = START;
        endcase
    end

    // Sample select and word assembly; the pad shift left-aligns 12-bit words
    always_comb begin
        curCh     = autoCh ? chCnt : (({1'b0, selCh} < NUM_CH_L) ? selCh : 2'd0);
        rawSample = '0;
        for (int k = 0; k < NUM_CH; k++)
            if (curCh == k[1:0]) rawSample = ADC_in[k*SAMPLE_W +: SAMPLE_W];
        sample  = testMode ? SAMPLE_W'(testCnt) : rawSample;
        accNext = {acc, sample};
        wordOut = accNext << PAD_W;
    end

    always_ff @(posedge InputClock) begin
        if (capturing) acc <= accNext[63-SAMPLE_W:0];
    end

    always_ff @(posedge InputClock) begin
        if (rst) begin
            cfg1        <= '0;
            cfg2        <= '0;
            bufLen      <= '0;
            sampCnt     <= '0;
            chCnt       <= '0;
            wordCnt     <= '0;
            frameCnt    <= '0;
            tlpWordCnt  <= '0;
            tlpCnt      <= '0;
            bufCnt      <= '0;
            testCnt     <= '0;
            DropCount   <= '0;
            ovfFlag     <= 1'b0;
            switchState <= 1'b0;
            SyncPulse   <= 1'b0;
            tlpBus.TLPData           <= '0;
            tlpBus.DataWriteEnable   <= 1'b0;
            tlpBus.TLPHeader         <= '0;
            tlpBus.HeaderWriteEnable <= 1'b0;
        end else begin
            testCnt                  <= testCnt + 8'd1;
            SyncPulse                <= capturing && inPulse;
            tlpBus.DataWriteEnable   <= emit;
            tlpBus.HeaderWriteEnable <= hdr;
            if (state == START) begin
                cfg1    <= CONFIG_REG_1;
                cfg2    <= CONFIG_REG_2[26:0];
                bufLen  <= BufferLengthTLPs;
                sampCnt <= '0;
                chCnt   <= '0;
                wordCnt <= '0;
            end
            if (capturing) begin
                sampCnt <= wordDone ? 3'd0 : sampCnt + 3'd1;
                chCnt   <= (frameDone || chCnt == LAST_CH) ? 2'd0 : chCnt + 2'd1;
                if (wordDone) wordCnt <= frameDone ? 13'd0 : wordCnt + 13'd1;
            end
            if (emit) begin
                tlpBus.TLPData <= wordOut;
                tlpWordCnt     <= hdr ? '0 : tlpWordCnt + TW'(1);
            end
            // Header carries counter values from before this TLP's increment
            if (hdr) begin
                tlpBus.TLPHeader <= {bufCnt, tlpCnt, curCh, Switcher, ovfFlag, 4'hF};
                if (tlpCnt == bufLen) begin
                    tlpCnt <= '0;
                    bufCnt <= bufCnt + 16'd1;
                end else begin
                    tlpCnt <= tlpCnt + 16'd1;
                end
            end
            if (state == DROP && frameDone) begin
                ovfFlag <= 1'b1;
                if (DropCount != 16'hFFFF) DropCount <= DropCount + 16'd1;
            end else if (hdr) begin
                ovfFlag <= 1'b0;
            end
            if (state == GAP) begin
                if (frameCnt == frameCountToSwitch) begin
                    frameCnt    <= '0;
                    switchState <= ~switchState;
                end else begin
                    frameCnt <= frameCnt + 24'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_adc_frame_packer.sv
// Directed bench: dutA (1 ch, 8-bit, test counter) exercises framing, headers, drop,
// sync pulse, switcher and reset; dutB (2 ch, 12-bit) exercises channel packing.
module tb_adc_frame_packer;
    logic InputClock = 1'b0;
    logic rst;
    always #5 InputClock = ~InputClock;

    int checks = 0;
    int errors = 0;

    adc_frame_packer_if busA ();
    adc_frame_packer_if busB ();

    logic [7:0]  adcA;
    logic [23:0] adcB;
    logic [31:0] cfg1A, cfg2A, cfg1B, cfg2B;
    logic [15:0] bufLenA, bufLenB, dropA, dropB;
    logic        syncA, switchA, syncB, switchB;

    adc_frame_packer #(.NUM_CH(1), .SAMPLE_W(8), .WORDS_PER_TLP(2)) dutA (
        .InputClock(InputClock), .rst(rst), .ADC_in(adcA),
        .CONFIG_REG_1(cfg1A), .CONFIG_REG_2(cfg2A), .BufferLengthTLPs(bufLenA),
        .tlpBus(busA), .SyncPulse(syncA), .Switcher(switchA), .DropCount(dropA));

    adc_frame_packer #(.NUM_CH(2), .SAMPLE_W(12), .WORDS_PER_TLP(16)) dutB (
        .InputClock(InputClock), .rst(rst), .ADC_in(adcB),
        .CONFIG_REG_1(cfg1B), .CONFIG_REG_2(cfg2B), .BufferLengthTLPs(bufLenB),
        .tlpBus(busB), .SyncPulse(syncB), .Switcher(switchB), .DropCount(dropB));

    task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    initial begin
        int firstDwe;
        int strobesInDrop;
        rst = 1'b1;
        adcA = 8'h5A;
        cfg1A = 32'h0100_2003;   // FrameLength 3, PulseWidth 1, PulseOffset 2
        cfg2A = 32'h0500_0001;   // FrameCountToSwitch 1, AutoPol, TestMode
        bufLenA = 16'd2;
        adcB = 24'h555AAA;
        cfg1B = 32'h0040_0003;   // FrameLength 3, AutoChSwitching
        cfg2B = 32'h0;
        bufLenB = 16'd4;
        busA.FifoAlmostFull = 1'b0;
        busB.FifoAlmostFull = 1'b0;

        repeat (3) @(posedge InputClock);
        #1;
        checkVal("rst_dwe",    64'(busA.DataWriteEnable), 64'd0);
        checkVal("rst_hwe",    64'(busA.HeaderWriteEnable), 64'd0);
        checkVal("rst_data",   busA.TLPData, 64'd0);
        checkVal("rst_header", 64'(busA.TLPHeader), 64'd0);
        checkVal("rst_sync",   64'(syncA), 64'd0);
        checkVal("rst_drop",   64'(dropA), 64'd0);
        checkVal("rst_switch", 64'(switchA), 64'd0);

        rst = 1'b0;
        firstDwe = 0;
        strobesInDrop = 0;
        for (int t = 1; t <= 140; t++) begin
            @(posedge InputClock);
            #1;
            if (busA.DataWriteEnable && firstDwe == 0) firstDwe = t;
            if (t >= 69 && t <= 101 && (busA.DataWriteEnable || busA.HeaderWriteEnable))
                strobesInDrop++;
            case (t)
                6: begin
                    checkVal("b_dwe_w0",  64'(busB.DataWriteEnable), 64'd1);
                    checkVal("b_data_w0", busB.TLPData, 64'hAAA555AAA555AAA0);
                end
                8:  checkVal("a_dwe_t8", 64'(busA.DataWriteEnable), 64'd0);
                9: begin
                    checkVal("a_dwe_t9",  64'(busA.DataWriteEnable), 64'd1);
                    checkVal("a_data_w0", busA.TLPData, 64'h0102030405060708);
                    checkVal("a_hwe_t9",  64'(busA.HeaderWriteEnable), 64'd0);
                end
                10: checkVal("a_dwe_t10", 64'(busA.DataWriteEnable), 64'd0);
                11: checkVal("b_data_w1", busB.TLPData, 64'h555AAA555AAA5550);
                17: begin
                    checkVal("a_data_w1", busA.TLPData, 64'h090A0B0C0D0E0F10);
                    checkVal("a_hwe_t17", 64'(busA.HeaderWriteEnable), 64'd1);
                    checkVal("a_hdr0",    64'(busA.TLPHeader), 64'h000000000F);
                    checkVal("a_sync_t17", 64'(syncA), 64'd0);
                end
                18: checkVal("a_sync_t18", 64'(syncA), 64'd1);
                28: checkVal("b_data_selch", busB.TLPData, 64'hAAAAAAAAAAAAAAA0);
                33: begin
                    checkVal("a_hdr1",     64'(busA.TLPHeader), 64'h000000010F);
                    checkVal("a_sync_t33", 64'(syncA), 64'd1);
                end
                34: checkVal("a_sync_t34", 64'(syncA), 64'd0);
                43: checkVal("a_data_f1w0", busA.TLPData, 64'h232425262728292A);
                51: checkVal("a_hdr2", 64'(busA.TLPHeader), 64'h000000020F);
                67: begin
                    checkVal("a_hdr3",     64'(busA.TLPHeader), 64'h000100000F);
                    checkVal("a_switch_t67", 64'(switchA), 64'd0);
                end
                68: checkVal("a_switch_t68", 64'(switchA), 64'd1);
                86: checkVal("a_sync_drop", 64'(syncA), 64'd1);
                100: checkVal("a_drop_t100", 64'(dropA), 64'd0);
                101: begin
                    checkVal("a_drop_t101", 64'(dropA), 64'd1);
                    checkVal("a_data_hold", busA.TLPData, 64'h3B3C3D3E3F404142);
                end
                111: checkVal("a_data_f3w0", busA.TLPData, 64'h6768696A6B6C6D6E);
                119: checkVal("a_hdr_ovf",   64'(busA.TLPHeader), 64'h000100013F);
                135: checkVal("a_hdr_clr",   64'(busA.TLPHeader), 64'h000100022F);
                136: checkVal("a_switch_t136", 64'(switchA), 64'd0);
                default: ;
            endcase
            if (t == 2)  cfg1B = 32'h0030_0003;   // SelectedCh 3, no auto switching
            if (t == 68) busA.FifoAlmostFull = 1'b1;
            if (t == 69) busA.FifoAlmostFull = 1'b0;
        end
        checkVal("a_first_dwe_latency", 64'(firstDwe), 64'd9);
        checkVal("a_drop_strobes", 64'(strobesInDrop), 64'd0);

        // Reset three samples into a word
        rst = 1'b1;
        repeat (2) @(posedge InputClock);
        #1;
        checkVal("mid_rst_dwe",  64'(busA.DataWriteEnable), 64'd0);
        checkVal("mid_rst_data", busA.TLPData, 64'd0);
        checkVal("mid_rst_drop", 64'(dropA), 64'd0);
        rst = 1'b0;
        firstDwe = 0;
        for (int u = 1; u <= 17; u++) begin
            @(posedge InputClock);
            #1;
            if (busA.DataWriteEnable && firstDwe == 0) firstDwe = u;
            if (u == 9)
                checkVal("post_rst_data", busA.TLPData, 64'h0102030405060708);
            if (u == 17) begin
                checkVal("post_rst_hwe", 64'(busA.HeaderWriteEnable), 64'd1);
                checkVal("post_rst_hdr", 64'(busA.TLPHeader), 64'h000000000F);
            end
        end
        checkVal("post_rst_latency", 64'(firstDwe), 64'd9);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/adc_frame_packer.md
ADC_FRAME_PACKER -- requirements
Module: adc_frame_packer

Interface
REQ-001 SHALL have parameter NUM_CH, default 2: number of ADC channels, 1 to 4.
REQ-002 SHALL have parameter SAMPLE_W, default 12: sample width, one of 8, 12 or 16; SPW = 8, 5 or 4 samples per 64-bit word.
REQ-003 SHALL have parameter WORDS_PER_TLP, default 16: data words per TLP, 2 to 64.
REQ-004 SHALL have ports:
  InputClock  in  1  ADC sample clock; all logic is on its rising edge.
  rst  in  1  reset, synchronous, active-high.
  ADC_in  in  NUM_CH*SAMPLE_W  channel k is in bits [k*SAMPLE_W +: SAMPLE_W].
  CONFIG_REG_1  in  32  [12:0] FrameLength (words), [19:13] PulseWidth, [21:20] SelectedCh, [22] AutoChSwitching, [31:23] PulseOffset.
  CONFIG_REG_2  in  32  [23:0] FrameCountToSwitch, [24] AutoPolSwitching, [25] ManualPolState, [26] TestMode.
  BufferLengthTLPs  in  16  last TLP index in a buffer.
  FifoAlmostFull  in  1  downstream FIFO cannot accept a full frame.
  TLPData  out  64  packed data word.
  DataWriteEnable  out  1  one-cycle strobe, TLPData valid.
  TLPHeader  out  40  TLP header.
  HeaderWriteEnable  out  1  one-cycle strobe, TLPHeader valid.
  SyncPulse  out  1  optical start pulse.
  Switcher  out  1  polarisation switch.
  DropCount  out  16  frames dropped since reset.

Function
REQ-005 SHALL latch CONFIG_REG_1, CONFIG_REG_2 and BufferLengthTLPs at each frame start only; mid-frame changes take effect at the next frame.
REQ-006 SHALL use FSM states START, FILL, DROP, GAP; START lasts one cycle and captures no sample.
REQ-007 In START, SHALL go to DROP if FifoAlmostFull=1, else to FILL.
REQ-008 In FILL or DROP, SHALL capture one sample per cycle; channel = sample index mod NUM_CH if AutoChSwitching=1, else SelectedCh (SelectedCh >= NUM_CH selects channel 0).
REQ-009 TestMode=1 SHALL replace each sample with an 8-bit free-running counter, zero-extended to SAMPLE_W; the counter increments every cycle except during reset.
REQ-010 SHALL pack samples MSB-first: sample 0 goes in bits [63:64-SAMPLE_W]; unused LSBs are 0 (4 bits for SAMPLE_W=12).
REQ-011 On the SPW-th sample of a word in FILL, SHALL update TLPData and pulse DataWriteEnable on the next cycle; TLPData holds until the next word.
REQ-012 SHALL increment the word counter per completed word in both FILL and DROP; after word index FrameLength (FrameLength+1 words), SHALL enter GAP for one cycle, then START.
REQ-013 DROP SHALL assert neither strobe; every other counter and output behaves as in FILL.
REQ-014 On leaving DROP, DropCount SHALL increment, saturating at 0xFFFF, and a sticky overflow flag SHALL be set.
REQ-015 SHALL count emitted words mod WORDS_PER_TLP; each time the WORDS_PER_TLP-th word is emitted, HeaderWriteEnable SHALL pulse in the same cycle as DataWriteEnable.
REQ-016 TLPHeader SHALL be {BufferCounter[15:0], TLPCounter[15:0], channel[1:0], Switcher, overflow flag, 4'b1111}, using values before the increment in REQ-017.
REQ-017 After each header, TLPCounter SHALL increment; if TLPCounter = BufferLengthTLPs, it SHALL instead wrap to 0 and BufferCounter SHALL increment, wrapping at 16 bits.
REQ-018 The overflow flag SHALL clear in the cycle its header is emitted; if the flag is set in the same cycle that a header emits, it stays set.
REQ-019 TLP word counts SHALL carry across frame boundaries; DROP frames do not advance them.
REQ-020 SyncPulse SHALL be registered; it is 1 while PulseOffset <= word counter <= PulseOffset+PulseWidth (10-bit sum, no overflow), in FILL and DROP, else 0.
REQ-021 The frame counter SHALL increment at each GAP; at GAP with frame counter = FrameCountToSwitch, it SHALL clear and the switch state SHALL toggle.
REQ-022 Switcher SHALL equal the switch state if AutoPolSwitching=1, else ManualPolState.

Reset
REQ-023 While rst=1, SHALL clear: FSM to START, every counter, DropCount, overflow flag, switch state, DataWriteEnable, HeaderWriteEnable, SyncPulse, TLPData and TLPHeader.
REQ-024 rst mid-frame SHALL abandon the partial word and frame without a strobe; a new frame starts with the first cycle after rst=0.

Verification
REQ-025 NUM_CH=1, SAMPLE_W=8, TestMode=1, FrameLength=3, WORDS_PER_TLP=2 -> first DataWriteEnable 9 cycles after rst release, TLPData=0x0102030405060708; header with TLPCounter=0 on word 2.
REQ-026 SAMPLE_W=12, NUM_CH=2, AutoChSwitching=1, ch0=0xAAA, ch1=0x555 -> TLPData=0xAAA555AAA555AAA0.
REQ-027 FifoAlmostFull=1 at one frame start -> no strobes for that frame, DropCount=1, next header bit 4 = 1, following header bit 4 = 0.
REQ-028 BufferLengthTLPs=2 -> header TLPCounter sequence 0,1,2,0 and BufferCounter 0,0,0,1.
REQ-029 PulseOffset=2, PulseWidth=1, FrameCountToSwitch=1, AutoPolSwitching=1 -> SyncPulse high for word counter 2..3 only; Switcher toggles every 2 frames.
REQ-030 rst asserted mid-word -> no strobe; after release, data restarts at word 0, TLPCounter=0.
